bu_buf_alloc: RTL
=================

# bu_buf_alloc

Slot allocator sitting directly upstream of the NOU buffer-slot register bank. It accepts allocation requests carrying a byte size, scans the slot bank one slot per cycle for the lowest-index FREE slot large enough, marks it BUSY through the shared slot write bus, and returns index/address/size over a valid/ready response. It also accepts single-cycle free commands that return BUSY slots to FREE.

## Interface
Parameters:
- SLOT_NUM, 8: number of slots; IDX_W = $clog2(SLOT_NUM), CNT_W = $clog2(SLOT_NUM+1)
- STATUS_W, 2: slot status width; encoding 0 FREE, 1 BUSY, 2 DISABLED, 3 reserved (treated as DISABLED)
- ADDR_W, 16: slot address width
- SZ_W, 12: slot size width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_req_vld  in  1  request valid
- alloc_req_rdy  out  1  request ready
- alloc_req_size  in  SZ_W  requested size
- alloc_rsp_vld  out  1  response valid
- alloc_rsp_rdy  in  1  response ready
- alloc_rsp_ok  out  1  1 = granted, 0 = no fitting slot
- alloc_rsp_idx / alloc_rsp_addr / alloc_rsp_size  out  IDX_W / ADDR_W / SZ_W  granted slot contents; 0 when ok=0
- free_vld  in  1  free command, single cycle, no backpressure
- free_idx  in  IDX_W  slot to free
- free_err  out  1  one-cycle pulse: illegal free
- slot_wr_en  out  SLOT_NUM  one-hot write strobe to slot registers
- slot_status / slot_addr / slot_size  out  STATUS_W / ADDR_W / SZ_W  shared write data
- slot_status_q / slot_addr_q / slot_size_q  in  SLOT_NUM*STATUS_W / *ADDR_W / *SZ_W  flattened slot readback, slot i at bits [i*W +: W]
- busy_cnt  out  CNT_W  number of BUSY slots

## Operation
- FSM IDLE, SCAN, RSP. alloc_req_rdy = (state==IDLE) && !rst.
- IDLE: on vld&&rdy latch size, ptr<=0, go SCAN.
- SCAN, per cycle, slot ptr:
  - free_vld high this cycle: stall, ptr holds, no alloc write (free owns the write bus).
  - req size 0: fail, go RSP.
  - status==FREE and size_q >= req size: slot_wr_en[ptr]=1, status=BUSY, addr/size = slot's current q values; latch idx/addr/size, ok=1, busy_cnt+1, go RSP.
  - else ptr==SLOT_NUM-1: ok=0, go RSP; else ptr+1.
- RSP: alloc_rsp_vld held with stable payload until alloc_rsp_rdy, then IDLE.
- Free, any state: free_idx < SLOT_NUM and slot BUSY -> slot_wr_en[free_idx]=1, status FREE, addr/size rewritten unchanged, busy_cnt-1. Otherwise (out of range, FREE, DISABLED) no write, free_err pulses next cycle.
- Alloc write and free write never share a cycle; busy_cnt never saturates/underflows.
- Freeing the slot currently granted in RSP is legal.
- Reset mid-operation: scan abandoned, no response issued. Slot registers share rst and carry their own reset contents.

## Timing
- Reset values: alloc_rsp_vld/ok/idx/addr/size 0, free_err 0, slot_wr_en 0, slot write data 0, busy_cnt 0, state IDLE.
- Handshake at cycle 0, first SCAN cycle 1; no stalls: grant of slot i writes in cycle 1+i, rsp_vld from 2+i.
- Full miss: rsp_vld (ok=0) from cycle SLOT_NUM+1; zero size: from cycle 2.
- Each free stall adds one cycle. Freed slot's q is updated next cycle, so a stalled scan on that slot sees FREE.
- Back-to-back requests: next request accepted the cycle after the response handshake.

## Test plan
- Reset, all slots FREE size 64; request size 32 -> rsp at cycle 2, ok=1, idx 0, slot 0 BUSY, busy_cnt 1.
- Slots 0-2 BUSY, slot 3 size 16, slot 4 size 128; request 100 -> write cycle 5, ok=1, idx 4, rsp_vld cycle 6.
- All slots BUSY or DISABLED; request 8 -> ok=0, idx/addr/size 0 at cycle 9 (SLOT_NUM=8); request size 0 -> ok=0 at cycle 2.
- Scan reaches slot 5 (BUSY) while free_vld idx 5 -> one stall, then idx 5 granted; busy_cnt unchanged net.
- Free of FREE slot, DISABLED slot, idx out of range -> free_err pulse each, no slot_wr_en, busy_cnt unchanged.
- Hold alloc_rsp_rdy low 10 cycles -> payload stable, rdy low; assert rst mid-scan -> all outputs reset next cycle, no response.

Source files
------------

// File: rtl/bu_buf_alloc.sv
// ---------------------------------------------------------------------------
// bu_buf_alloc
//   Slot allocator in front of the NOU buffer-slot register bank. A request
//   carrying a byte size starts a scan of the bank, one slot per cycle from
//   index 0. The first FREE slot whose size is large enough is marked BUSY
//   through the shared slot write bus. Its index/address/size is then
//   returned on a valid/ready response. Single-cycle free commands return
//   BUSY slots to FREE; an illegal free raises a one-cycle error pulse.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   alloc_req_vld/rdy/size    allocation request (valid/ready)
//   alloc_rsp_vld/rdy         allocation response (valid/ready)
//   alloc_rsp_ok/idx/addr/size  grant result, payload zero on a miss
//   free_vld, free_idx        free command, no backpressure
//   free_err                  pulse one cycle after an illegal free
//   slot_wr_en                one-hot write strobe into the slot bank
//   slot_status/addr/size     shared write data for the slot bank
//   slot_status_q/addr_q/size_q  flattened bank readback, slot i at [i*W +: W]
//   busy_cnt                  number of slots currently BUSY
// ---------------------------------------------------------------------------
module bu_buf_alloc #(
  parameter int SLOT_NUM = 8,
  parameter int STATUS_W = 2,
  parameter int ADDR_W   = 16,
  parameter int SZ_W     = 12,
  localparam int IDX_W   = $clog2(SLOT_NUM),
  localparam int CNT_W   = $clog2(SLOT_NUM + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_req_vld,
  output logic                         alloc_req_rdy,
  input  logic [SZ_W-1:0]              alloc_req_size,
  output logic                         alloc_rsp_vld,
  input  logic                         alloc_rsp_rdy,
  output logic                         alloc_rsp_ok,
  output logic [IDX_W-1:0]             alloc_rsp_idx,
  output logic [ADDR_W-1:0]            alloc_rsp_addr,
  output logic [SZ_W-1:0]              alloc_rsp_size,
  input  logic                         free_vld,
  input  logic [IDX_W-1:0]             free_idx,
  output logic                         free_err,
  output logic [SLOT_NUM-1:0]          slot_wr_en,
  output logic [STATUS_W-1:0]          slot_status,
  output logic [ADDR_W-1:0]            slot_addr,
  output logic [SZ_W-1:0]              slot_size,
  input  logic [SLOT_NUM*STATUS_W-1:0] slot_status_q,
  input  logic [SLOT_NUM*ADDR_W-1:0]   slot_addr_q,
  input  logic [SLOT_NUM*SZ_W-1:0]     slot_size_q,
  output logic [CNT_W-1:0]             busy_cnt
);

  localparam logic [STATUS_W-1:0] ST_FREE  = STATUS_W'(0);
  localparam logic [STATUS_W-1:0] ST_BUSY  = STATUS_W'(1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(SLOT_NUM - 1);
  localparam logic [IDX_W:0]      SLOT_LIM = (IDX_W + 1)'(SLOT_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RSP  = 2'd2
  } state_e;

  state_e              state_r;
  logic [IDX_W-1:0]    ptr_r;
  logic [SZ_W-1:0]     req_size_r;
  logic                rsp_vld_r;
  logic                rsp_ok_r;
  logic [IDX_W-1:0]    rsp_idx_r;
  logic [ADDR_W-1:0]   rsp_addr_r;
  logic [SZ_W-1:0]     rsp_size_r;
  logic                free_err_r;
  logic [CNT_W-1:0]    busy_cnt_r;

  logic [STATUS_W-1:0] ptr_status_s;
  logic [ADDR_W-1:0]   ptr_addr_s;
  logic [SZ_W-1:0]     ptr_size_s;
  logic                free_in_range_s;
  logic [IDX_W-1:0]    free_sel_s;
  logic [STATUS_W-1:0] free_status_s;
  logic [ADDR_W-1:0]   free_addr_s;
  logic [SZ_W-1:0]     free_size_s;
  logic                free_ok_s;
  logic                scan_run_s;
  logic                grant_s;
  logic [SLOT_NUM-1:0] wr_en_s;
  logic [STATUS_W-1:0] wr_status_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [SZ_W-1:0]     wr_size_s;

  // Readback of the slot under the scan pointer.
  assign ptr_status_s = slot_status_q[ptr_r*STATUS_W +: STATUS_W];
  assign ptr_addr_s   = slot_addr_q[ptr_r*ADDR_W +: ADDR_W];
  assign ptr_size_s   = slot_size_q[ptr_r*SZ_W +: SZ_W];

  // An out-of-range free index is redirected to slot 0 so the readback
  // select always stays inside the bank; legality is decided separately.
  assign free_in_range_s = ({1'b0, free_idx} < SLOT_LIM);
  assign free_sel_s      = free_in_range_s ? free_idx : {IDX_W{1'b0}};
  assign free_status_s   = slot_status_q[free_sel_s*STATUS_W +: STATUS_W];
  assign free_addr_s     = slot_addr_q[free_sel_s*ADDR_W +: ADDR_W];
  assign free_size_s     = slot_size_q[free_sel_s*SZ_W +: SZ_W];

  assign free_ok_s  = !rst && free_vld && free_in_range_s && (free_status_s == ST_BUSY);
  // Any free command owns the write bus for its cycle, so the scan holds.
  assign scan_run_s = !rst && (state_r == S_SCAN) && !free_vld;
  assign grant_s    = scan_run_s && (req_size_r != {SZ_W{1'b0}}) &&
                      (ptr_status_s == ST_FREE) && (ptr_size_s >= req_size_r);

  // Shared slot write bus: a legal free or a grant, never both in one cycle.
  always_comb begin
    wr_en_s     = {SLOT_NUM{1'b0}};
    wr_status_s = {STATUS_W{1'b0}};
    wr_addr_s   = {ADDR_W{1'b0}};
    wr_size_s   = {SZ_W{1'b0}};
    if (free_ok_s) begin
      wr_en_s[free_idx] = 1'b1;
      wr_status_s       = ST_FREE;
      wr_addr_s         = free_addr_s;
      wr_size_s         = free_size_s;
    end else if (grant_s) begin
      wr_en_s[ptr_r] = 1'b1;
      wr_status_s    = ST_BUSY;
      wr_addr_s      = ptr_addr_s;
      wr_size_s      = ptr_size_s;
    end else begin
      wr_en_s = {SLOT_NUM{1'b0}};
    end
  end

  // Request/scan/response FSM with its registered outputs and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      ptr_r      <= {IDX_W{1'b0}};
      req_size_r <= {SZ_W{1'b0}};
      rsp_vld_r  <= 1'b0;
      rsp_ok_r   <= 1'b0;
      rsp_idx_r  <= {IDX_W{1'b0}};
      rsp_addr_r <= {ADDR_W{1'b0}};
      rsp_size_r <= {SZ_W{1'b0}};
      free_err_r <= 1'b0;
      busy_cnt_r <= {CNT_W{1'b0}};
    end else begin
      free_err_r <= free_vld && !free_ok_s;
      if (free_ok_s) begin
        busy_cnt_r <= busy_cnt_r - CNT_W'(1);
      end else if (grant_s) begin
        busy_cnt_r <= busy_cnt_r + CNT_W'(1);
      end else begin
        busy_cnt_r <= busy_cnt_r;
      end
      case (state_r)
        S_IDLE: begin
          if (alloc_req_vld) begin
            req_size_r <= alloc_req_size;
            ptr_r      <= {IDX_W{1'b0}};
            state_r    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (free_vld) begin
            ptr_r <= ptr_r;
          end else if (grant_s) begin
            rsp_vld_r  <= 1'b1;
            rsp_ok_r   <= 1'b1;
            rsp_idx_r  <= ptr_r;
            rsp_addr_r <= ptr_addr_s;
            rsp_size_r <= ptr_size_s;
            state_r    <= S_RSP;
          end else if ((req_size_r == {SZ_W{1'b0}}) || (ptr_r == LAST_IDX)) begin
            rsp_vld_r  <= 1'b1;
            rsp_ok_r   <= 1'b0;
            rsp_idx_r  <= {IDX_W{1'b0}};
            rsp_addr_r <= {ADDR_W{1'b0}};
            rsp_size_r <= {SZ_W{1'b0}};
            state_r    <= S_RSP;
          end else begin
            ptr_r <= ptr_r + IDX_W'(1);
          end
        end
        S_RSP: begin
          if (alloc_rsp_rdy) begin
            rsp_vld_r <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          rsp_vld_r <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  assign alloc_req_rdy  = (state_r == S_IDLE) && !rst;
  assign alloc_rsp_vld  = rsp_vld_r;
  assign alloc_rsp_ok   = rsp_ok_r;
  assign alloc_rsp_idx  = rsp_idx_r;
  assign alloc_rsp_addr = rsp_addr_r;
  assign alloc_rsp_size = rsp_size_r;
  assign free_err       = free_err_r;
  assign slot_wr_en     = wr_en_s;
  assign slot_status    = wr_status_s;
  assign slot_addr      = wr_addr_s;
  assign slot_size      = wr_size_s;
  assign busy_cnt       = busy_cnt_r;

endmodule
